rv32_fetch_unit: RTL

Instruction fetch stage of the rv32 pipeline. It is the producer side of the fetch-to-decode interface and feeds pc, instr and branch_predicted_taken into decode.
- Owns the PC register and drives the instruction memory read bus.
- Applies static branch prediction.
- Handles hazard stall/flush and execute-stage redirects.
- Injects NOP bubbles whenever no valid instruction is available.

---
 rtl/rv32_control.sv | 25 ++
 rtl/rv32_branch_predictor.sv | 36 +++
 rtl/rv32_fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/rv32_control.sv
// Shared rv32 control definitions: opcodes, NOP encoding, fetch FSM states and
// the fetch-to-decode stage record.
package rv32_control;

  localparam logic [6:0]  RV32_OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0]  RV32_OPCODE_BRANCH = 7'b1100011;
  localparam logic [31:0] RV32_INSTR_NOP     = 32'h0000_0013;

  typedef enum logic {
    RV32_FETCH_STATE_FETCH = 1'b0,
    RV32_FETCH_STATE_DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } fetch_out_t;

  function automatic fetch_out_t fetch_bubble(input logic [31:0] pc);
    fetch_bubble = '{valid: 1'b0, pc: pc, instr: RV32_INSTR_NOP, pred: 1'b0};
  endfunction

endpackage

// File: rtl/rv32_branch_predictor.sv
// Static predictor, purely combinational: JAL taken, backward B-type taken.
// offset is the decoded J/B immediate; taken is forced low when prediction is disabled.
module rv32_branch_predictor
  import rv32_control::*;
#(
  parameter bit PREDICT_BRANCHES = 1'b1
) (
  input  logic [31:0] instr,
  output logic        taken,
  output logic [31:0] offset
);

  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    taken  = 1'b0;
    offset = 32'd0;
    case (instr[6:0])
      RV32_OPCODE_JAL: begin
        taken  = 1'b1;
        offset = j_imm;
      end
      RV32_OPCODE_BRANCH: begin
        taken  = b_imm[31];
        offset = b_imm;
      end
      default: ;
    endcase
    if (!PREDICT_BRANCHES) taken = 1'b0;
  end

endmodule

// File: rtl/rv32_fetch_unit.sv
// Fetch stage: owns the PC, drives the imem bus, registers pc/instr/prediction one cycle
// after an accepted request; a redirect against an unanswered request drains it first.
module rv32_fetch_unit
  import rv32_control::*;
#(
  parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
  parameter bit          PREDICT_BRANCHES = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] instr_address_out,
  output logic        instr_read_out,
  input  logic        instr_ready_in,
  input  logic [31:0] instr_read_value_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        branch_predicted_taken_out
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_q, pending_d;
  fetch_out_t   out_q, out_d;
  logic [31:0]  redirect_target;
  logic         pred_taken;
  logic [31:0]  pred_offset;

  rv32_branch_predictor #(
    .PREDICT_BRANCHES(PREDICT_BRANCHES)
  ) u_predictor (
    .instr (instr_read_value_in),
    .taken (pred_taken),
    .offset(pred_offset)
  );

  assign redirect_target   = redirect_pc_in & ~32'd3;
  assign instr_address_out = pc_q;
  assign instr_read_out    = (state_q == RV32_FETCH_STATE_FETCH) ? !stall_in : 1'b1;

  assign valid_out                  = out_q.valid;
  assign pc_out                     = out_q.pc;
  assign instr_out                  = out_q.instr;
  assign branch_predicted_taken_out = out_q.pred;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RV32_FETCH_STATE_FETCH;
      pc_q      <= RESET_VECTOR;
      pending_q <= 32'd0;
      out_q     <= fetch_bubble(32'd0);
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    out_d     = out_q;
    case (state_q)
      RV32_FETCH_STATE_FETCH: begin
        if (redirect_in) begin
          out_d = fetch_bubble(pc_q);
          // An unanswered request must keep its address until memory responds.
          if (instr_ready_in || !instr_read_out) begin
            pc_d = redirect_target;
          end else begin
            pending_d = redirect_target;
            state_d   = RV32_FETCH_STATE_DRAIN;
          end
        end else if (!stall_in) begin
          if (!flush_in && instr_ready_in) begin
            out_d = '{valid: 1'b1, pc: pc_q, instr: instr_read_value_in, pred: pred_taken};
            pc_d  = pred_taken ? pc_q + pred_offset : pc_q + 32'd4;
          end else begin
            out_d = fetch_bubble(pc_q);
          end
        end
      end
      RV32_FETCH_STATE_DRAIN: begin
        out_d = fetch_bubble(pc_q);
        if (redirect_in) pending_d = redirect_target;
        if (instr_ready_in) begin
          pc_d    = redirect_in ? redirect_target : pending_q;
          state_d = RV32_FETCH_STATE_FETCH;
        end
      end
      default: state_d = RV32_FETCH_STATE_FETCH;
    endcase
  end

endmodule
